spi_peripheral: RTL and testbench

//  SPI peripheral (target) end of our SPI link, CPOL=1/CPHA=0, MSB first. Samples SPI_CLK/SPI_EN/SPI_MOSI

---
 rtl/spi_peripheral.sv | 136 +++++++++++++
 tb/tb_spi_peripheral.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral.sv
// spi_peripheral: CPOL-configurable, CPHA=0, MSB-first SPI target with clk-domain oversampling of the SPI pins,
// a one-deep transmit holding register and pulse-style rx/underrun/framing status.
module spi_peripheral #(
  parameter int                    DATA_WIDTH  = 8,
  parameter bit                    CPOL        = 1'b1,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] TX_DEFAULT  = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SPI_CLK,
  input  logic                  SPI_EN,
  input  logic                  SPI_MOSI,
  output logic                  SPI_MISO,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  frame_err
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
  typedef enum logic {IDLE, SHIFT} state_e;
  state_e state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_q, en_q, mosi_q, vld_q;
  logic sclk_h_q, en_h_q, armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d, rx_data_q, rx_data_d, load_val;
  logic hold_full_q, hold_full_d, miso_q, miso_d;
  logic rx_valid_q, rx_valid_d, underrun_q, underrun_d, frame_err_q, frame_err_d;
  logic sclk_s, en_s, mosi_s, lead, trail, en_rise, en_fall, wr, load;
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q   <= {SYNC_STAGES{CPOL}};
      en_q     <= '0;
      mosi_q   <= '0;
      vld_q    <= '0;
      sclk_h_q <= CPOL;
      en_h_q   <= 1'b0;
    end else begin
      sclk_q   <= {sclk_q[SYNC_STAGES-2:0], SPI_CLK};
      en_q     <= {en_q[SYNC_STAGES-2:0], SPI_EN};
      mosi_q   <= {mosi_q[SYNC_STAGES-2:0], SPI_MOSI};
      vld_q    <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      sclk_h_q <= sclk_s;
      en_h_q   <= en_s;
    end
  end
  assign sclk_s   = sclk_q[SYNC_STAGES-1];
  assign en_s     = en_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_q[SYNC_STAGES-1];
  assign lead     = (sclk_s != sclk_h_q) && (sclk_h_q == CPOL);
  assign trail    = (sclk_s != sclk_h_q) && (sclk_h_q != CPOL);
  // A session may only start once EN has been seen low with flushed synchronizers after reset.
  assign en_rise  = armed_q & en_s & ~en_h_q;
  assign en_fall  = ~en_s & en_h_q;
  assign wr       = tx_valid & ~hold_full_q;
  assign load     = (state_q == IDLE) ? en_rise : (!en_fall && trail && cnt_q == '0);
  assign load_val = hold_full_q ? hold_q : TX_DEFAULT;
  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q | (vld_q[SYNC_STAGES-1] & ~en_s);
    cnt_d       = cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    miso_d      = miso_q;
    hold_d      = wr ? tx_data : hold_q;
    hold_full_d = wr | (hold_full_q & ~load);
    rx_valid_d  = 1'b0;
    underrun_d  = load & ~hold_full_q;
    frame_err_d = 1'b0;
    if (cnt_q == CNT_FULL) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
      cnt_d      = '0;
    end
    if (load) begin
      tx_shift_d = load_val;
      miso_d     = load_val[DATA_WIDTH-1];
      cnt_d      = '0;
    end
    if (state_q == IDLE) begin
      state_d = en_rise ? SHIFT : IDLE;
    end else if (en_fall) begin
      state_d     = IDLE;
      miso_d      = 1'b0;
      cnt_d       = '0;
      frame_err_d = (cnt_q != '0) && (cnt_q != CNT_FULL);
    end else if (lead) begin
      rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
      cnt_d      = cnt_q + 1'b1;
    end else if (trail && cnt_q != '0) begin
      miso_d     = tx_shift_q[DATA_WIDTH-2];
      tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], tx_shift_q[DATA_WIDTH-1]};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      miso_q      <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      miso_q      <= miso_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign SPI_MISO    = miso_q;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign frame_err   = frame_err_q;
endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: directed SPI initiator driving spi_peripheral with hand-computed expectations.
module tb_spi_peripheral;
  localparam int H = 5;
  logic clk = 1'b0, rst = 1'b1;
  logic spi_clk = 1'b1, spi_en = 1'b0, spi_mosi = 1'b0, spi_miso;
  logic [7:0] tx_data = '0, rx_data;
  logic tx_valid = 1'b0, tx_ready, rx_valid, tx_underrun, frame_err;
  int n_cmp = 0, n_err = 0;
  int cyc = 0, lead_cyc = 0, rv_cyc = 0;
  int rx_n = 0, ur_n = 0, fe_n = 0;
  logic [7:0] rxq[$];
  spi_peripheral dut (
    .clk(clk), .rst(rst), .SPI_CLK(spi_clk), .SPI_EN(spi_en), .SPI_MOSI(spi_mosi),
    .SPI_MISO(spi_miso), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        rx_n++;
        rv_cyc = cyc;
        rxq.push_back(rx_data);
      end
      if (tx_underrun) ur_n++;
      if (frame_err) fe_n++;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tx_write(input logic [7:0] d);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask
  task automatic spi_byte(input logic [7:0] mo, input int nb, input int h, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nb; i++) begin
      spi_mosi = mo[7-i];
      repeat (h) @(negedge clk);
      mi[7-i] = spi_miso;
      spi_clk = 1'b0;
      lead_cyc = cyc;
      repeat (h) @(negedge clk);
      spi_clk = 1'b1;
    end
  endtask
  task automatic en_on(input int h);
    spi_en = 1'b1;
    repeat (h) @(negedge clk);
  endtask
  task automatic en_off(input int h);
    repeat (h) @(negedge clk);
    spi_en = 1'b0;
    repeat (2 * h) @(negedge clk);
  endtask
  initial begin
    logic [7:0] m1, m2;
    int u0, r0, f0;
    repeat (3) @(negedge clk);
    check("rst_miso", spi_miso, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_underrun", tx_underrun, 0);
    check("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    // empty holding register: default byte out, underrun at EN rise and again at the final boundary load
    rxq.delete(); u0 = ur_n; r0 = rx_n;
    en_on(H);
    check("t3_ur_en", ur_n - u0, 1);
    spi_byte(8'h00, 8, H, m1);
    check("t3_ur_bytes", ur_n - u0, 1);
    en_off(H);
    check("t3_ur_bnd", ur_n - u0, 2);
    check("t3_miso", m1, 8'hFF);
    check("t3_rx_n", rx_n - r0, 1);
    check("t3_rx0", rxq[0], 8'h00);
    // two bytes in one session, second tx byte written mid first byte
    tx_write(8'h11);
    rxq.delete(); u0 = ur_n; r0 = rx_n; f0 = fe_n;
    en_on(H);
    fork
      spi_byte(8'h5A, 8, H, m1);
      begin repeat (30) @(negedge clk); tx_write(8'h22); end
    join
    spi_byte(8'hC3, 8, H, m2);
    check("t2_ur", ur_n - u0, 0);
    en_off(H);
    check("t2_miso0", m1, 8'h11);
    check("t2_miso1", m2, 8'h22);
    check("t2_rx_n", rx_n - r0, 2);
    check("t2_rx0", rxq[0], 8'h5A);
    check("t2_rx1", rxq[1], 8'hC3);
    check("t2_fe", fe_n - f0, 0);
    // single byte with a held tx byte
    tx_write(8'hA5);
    check("t1_ready_lo", tx_ready, 0);
    rxq.delete(); r0 = rx_n;
    en_on(H);
    check("t1_ready_hi", tx_ready, 1);
    spi_byte(8'h3C, 8, H, m1);
    en_off(H);
    check("t1_miso", m1, 8'hA5);
    check("t1_rx_n", rx_n - r0, 1);
    check("t1_rx0", rxq[0], 8'h3C);
    check("t1_rx_data", rx_data, 8'h3C);
    // EN dropped after 5 bits: frame error, partial byte discarded
    rxq.delete(); r0 = rx_n; f0 = fe_n;
    en_on(H);
    spi_byte(8'hF0, 5, H, m1);
    en_off(H);
    check("t4_fe", fe_n - f0, 1);
    check("t4_rx_n", rx_n - r0, 0);
    check("t4_rx_data", rx_data, 8'h3C);
    check("t4_miso_idle", spi_miso, 0);
    tx_write(8'h7E);
    en_on(H);
    spi_byte(8'h81, 8, H, m1);
    en_off(H);
    check("t4_next_miso", m1, 8'h7E);
    check("t4_next_rx", rxq[0], 8'h81);
    check("t4_fe_once", fe_n - f0, 1);
    // reset mid-transfer, released with EN still high
    tx_write(8'hC6);
    en_on(H);
    spi_byte(8'hFF, 3, H, m1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_miso", spi_miso, 0);
    check("t5_tx_ready", tx_ready, 1);
    check("t5_rx_data", rx_data, 0);
    check("t5_rx_valid", rx_valid, 0);
    rxq.delete(); u0 = ur_n; r0 = rx_n; f0 = fe_n;
    spi_byte(8'h55, 8, H, m1);
    repeat (H) @(negedge clk);
    check("t5_ign_rx", rx_n - r0, 0);
    check("t5_ign_ur", ur_n - u0, 0);
    check("t5_ign_miso", m1, 8'h00);
    en_off(H);
    check("t5_ign_fe", fe_n - f0, 0);
    en_on(H);
    spi_byte(8'h96, 8, H, m1);
    en_off(H);
    check("t5_rx", rxq[0], 8'h96);
    check("t5_rx_n", rx_n - r0, 1);
    check("t5_miso_dflt", m1, 8'hFF);
    check("t5_fe", fe_n - f0, 0);
    // latency: rx_valid SYNC_STAGES+2 clk after the 8th leading pin edge
    rxq.delete(); r0 = rx_n;
    en_on(4);
    spi_byte(8'hA7, 8, 4, m1);
    repeat (8) @(negedge clk);
    check("t6_latency", rv_cyc - lead_cyc, 4);
    check("t6_rx", rxq[0], 8'hA7);
    en_off(4);
    check("t6_rx_n", rx_n - r0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
